// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch bus for cpu_control_unit.
// The CPU side (master) drives the address and request; the memory side
// (slave) returns the byte and the acknowledge.
interface cpu_control_unit_if;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic [7:0] imem_rdata;
  logic       imem_ack;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control/execute stage of the 8-bit soft CPU.
// It fetches over a req/ack bus, decodes the instruction, drives the register
// file and updates the PC and the Z/N flags.
// Optional macro CPU_ILLEGAL_TRAP_EN: opcodes 0x8-0xE halt with illegal=1.
// When the macro is not defined, those opcodes behave as NOP.
module cpu_control_unit (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  cpu_control_unit_if.master        imem,
  output logic                      RFWrite,
  output logic [1:0]                regA,
  output logic [1:0]                regB,
  output logic [1:0]                regW,
  output logic [7:0]                dataW,
  input  logic [7:0]                dataA,
  input  logic [7:0]                dataB,
  output logic [7:0]                pc,
  output logic                      zero_flag,
  output logic                      neg_flag,
  output logic                      halted,
  output logic                      illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOADI = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_NAND  = 4'h4,
    OP_MOV   = 4'h5,
    OP_BZ    = 4'h6,
    OP_BNZ   = 4'h7,
    OP_HALT  = 4'hF
  } op_t;

  state_t     state_q;
  logic [7:0] ir_q;
  logic [7:0] pc_q;
  logic [7:0] addr_q;
  logic       req_q;
  logic       rfwrite_q;
  logic [7:0] dataw_q;
  logic       z_q;
  logic       n_q;
  logic       halted_q;

  logic [3:0] opcode;
  logic [7:0] alu_d;
  logic [7:0] pc_inc_d;
  logic [7:0] br_target_d;
  logic       br_taken_d;
  logic [7:0] exec_pc_d;
  logic       writes_d;
  logic       flags_upd_d;

  // Decode of the held instruction: ALU result, write/flag enables, next PC.
  always_comb begin
    opcode      = ir_q[7:4];
    alu_d       = '0;
    writes_d    = 1'b0;
    flags_upd_d = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_d = dataA + dataB;    writes_d = 1'b1; flags_upd_d = 1'b1; end
      OP_SUB:  begin alu_d = dataA - dataB;    writes_d = 1'b1; flags_upd_d = 1'b1; end
      OP_NAND: begin alu_d = ~(dataA & dataB); writes_d = 1'b1; flags_upd_d = 1'b1; end
      OP_MOV:  begin alu_d = dataB;            writes_d = 1'b1; end
      default: ;
    endcase
    pc_inc_d    = pc_q + 8'd1;
    // In EXEC pc_q already points past the branch, so it is PC_next.
    br_target_d = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
    br_taken_d  = ((opcode == OP_BZ)  &&  z_q) ||
                  ((opcode == OP_BNZ) && !z_q);
    exec_pc_d   = br_taken_d ? br_target_d : pc_q;
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_op_d;

  // Undefined opcodes are 0x8 through 0xE.
  always_comb begin
    illegal_op_d = ir_q[7] && (ir_q[7:4] != OP_HALT);
  end
`endif

  // Main sequencer: every output and architectural register is updated here.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      rfwrite_q <= 1'b0;
      dataw_q   <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      halted_q  <= 1'b0;
`ifdef CPU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            ir_q    <= imem.imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          pc_q <= pc_inc_d;
          if (opcode == OP_LOADI) begin
            req_q   <= 1'b1;
            addr_q  <= pc_inc_d;
            state_q <= S_IMM;
          end else if (opcode == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
`ifdef CPU_ILLEGAL_TRAP_EN
          end else if (illegal_op_d) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
`endif
          end else begin
            // Result is registered here so dataW is stable for the whole EXEC cycle.
            rfwrite_q <= writes_d;
            if (writes_d) begin
              dataw_q <= alu_d;
            end
            state_q <= S_EXEC;
          end
        end
        S_IMM: begin
          if (imem.imem_ack) begin
            dataw_q   <= imem.imem_rdata;
            rfwrite_q <= 1'b1;
            req_q     <= 1'b0;
            pc_q      <= pc_inc_d;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rfwrite_q <= 1'b0;
          if (flags_upd_d) begin
            z_q <= (dataw_q == 8'h00);
            n_q <= dataw_q[7];
          end
          pc_q    <= exec_pc_d;
          addr_q  <= exec_pc_d;
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.imem_addr = addr_q;
  assign imem.imem_req  = req_q;
  assign RFWrite        = rfwrite_q;
  assign regA           = ir_q[3:2];
  assign regB           = ir_q[1:0];
  assign regW           = ir_q[3:2];
  assign dataW          = dataw_q;
  assign pc             = pc_q;
  assign zero_flag      = z_q;
  assign neg_flag       = n_q;
  assign halted         = halted_q;
`ifdef CPU_ILLEGAL_TRAP_EN
  assign illegal        = illegal_q;
`else
  assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a ROM with programmable ack delay and
// a four-entry register file surround the DUT; each program runs to HALT and
// the final architectural state is compared with hand-computed values.
module tb_cpu_control_unit;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       RFWrite;
  logic [1:0] regA, regB, regW;
  logic [7:0] dataW, dataA, dataB, pc;
  logic       zero_flag, neg_flag, halted, illegal;

  cpu_control_unit_if bus ();

  cpu_control_unit u_dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .imem      (bus),
    .RFWrite   (RFWrite),
    .regA      (regA),
    .regB      (regB),
    .regW      (regW),
    .dataW     (dataW),
    .dataA     (dataA),
    .dataB     (dataB),
    .pc        (pc),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] rom [256];
  logic [7:0] rf  [4];
  int         ack_delay = 0;
  int         wcnt = 0;

  assign bus.imem_rdata = rom[bus.imem_addr];
  assign bus.imem_ack   = bus.imem_req && (wcnt == ack_delay);
  assign dataA          = rf[regA];
  assign dataB          = rf[regB];

  int         errors = 0;
  int         checks = 0;
  int         rf_pulses, rf_long, addr_viol, ack4;
  logic       rf_prev, wrap_inc, wrap_br;
  logic       req_prev, ack_prev;
  logic [7:0] addr_prev, last_ack;

  // Environment: memory wait counter, register-file write, bus observers.
  always @(posedge CLOCK_50) begin
    if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
    if (RFWrite) rf[regW] <= dataW;
    if (resetn) begin
      rf_prev <= RFWrite;
      if (RFWrite && !rf_prev) rf_pulses <= rf_pulses + 1;
      if (RFWrite &&  rf_prev) rf_long   <= rf_long + 1;
      if (req_prev && !ack_prev && bus.imem_req && (bus.imem_addr != addr_prev))
        addr_viol <= addr_viol + 1;
      req_prev  <= bus.imem_req;
      ack_prev  <= bus.imem_ack;
      addr_prev <= bus.imem_addr;
      if (bus.imem_req && bus.imem_ack) begin
        last_ack <= bus.imem_addr;
        if (bus.imem_addr == 8'h04) ack4 <= ack4 + 1;
        if (last_ack == 8'hFF && bus.imem_addr == 8'h00) wrap_inc <= 1'b1;
        if (last_ack == 8'hFE && bus.imem_addr == 8'h06) wrap_br  <= 1'b1;
      end
    end else begin
      rf_prev  <= 1'b0;
      req_prev <= 1'b0;
      ack_prev <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Resets the DUT, clears observers and register file, runs until halted.
  task automatic run_prog(input string name, input int delay, output int cycles);
    ack_delay = delay;
    resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    rf_pulses = 0; rf_long = 0; addr_viol = 0; ack4 = 0;
    wrap_inc = 1'b0; wrap_br = 1'b0; last_ack = 8'h00;
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    chk({name, "_first_req"}, bus.imem_req, 1);
    cycles = 0;
    while (!halted && cycles < 500) begin
      @(posedge CLOCK_50); #1;
      cycles++;
    end
  endtask

  int n;

  initial begin
    // Reset state
    repeat (2) @(posedge CLOCK_50); #1;
    chk("rst_req",   bus.imem_req,  0);
    chk("rst_addr",  bus.imem_addr, 0);
    chk("rst_rfw",   RFWrite,       0);
    chk("rst_regs",  {regA, regB, regW}, 0);
    chk("rst_dataW", dataW,         0);
    chk("rst_pc",    pc,            0);
    chk("rst_flags", {zero_flag, neg_flag}, 0);
    chk("rst_halt",  {halted, illegal}, 0);

    // Straight-line program, zero-wait ROM
    clear_rom();
    rom[0] = 8'h14; rom[1] = 8'h05; rom[2] = 8'h18; rom[3] = 8'h03;
    rom[4] = 8'h36; rom[5] = 8'hF0;
    run_prog("p1", 0, n);
    chk("p1_cycles", n, 13);
    chk("p1_R1", rf[1], 8'h02);
    chk("p1_R2", rf[2], 8'h03);
    chk("p1_ZN", {zero_flag, neg_flag}, 2'b00);
    chk("p1_halted", halted, 1);
    chk("p1_pc", pc, 8'h06);
    chk("p1_rf_pulses", rf_pulses, 3);
    chk("p1_rf_long", rf_long, 0);

    // Same program, three wait cycles per fetch
    run_prog("p1d", 3, n);
    chk("p1d_cycles", n, 31);
    chk("p1d_R1", rf[1], 8'h02);
    chk("p1d_R2", rf[2], 8'h03);
    chk("p1d_pc", pc, 8'h06);
    chk("p1d_addr_stable", addr_viol, 0);
    chk("p1d_rf_pulses", rf_pulses, 3);

    // Countdown loop with BNZ
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h03; rom[2] = 8'h14; rom[3] = 8'h01;
    rom[4] = 8'h31; rom[5] = 8'h7E; rom[6] = 8'hF0;
    run_prog("loop", 0, n);
    chk("loop_cycles", n, 28);
    chk("loop_R0", rf[0], 8'h00);
    chk("loop_ZN", {zero_flag, neg_flag}, 2'b10);
    chk("loop_pc", pc, 8'h07);
    chk("loop_fetch4", ack4, 3);
    chk("loop_rf_pulses", rf_pulses, 5);

    // ADD / MOV / NAND and the N flag
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h80; rom[2] = 8'h14; rom[3] = 8'h7F;
    rom[4] = 8'h21; rom[5] = 8'h58; rom[6] = 8'h4A; rom[7] = 8'h28;
    rom[8] = 8'h5D; rom[9] = 8'hF0;
    run_prog("alu", 0, n);
    chk("alu_cycles", n, 25);
    chk("alu_R0", rf[0], 8'hFF);
    chk("alu_R1", rf[1], 8'h7F);
    chk("alu_R2", rf[2], 8'hFF);
    chk("alu_R3", rf[3], 8'h7F);
    chk("alu_ZN", {zero_flag, neg_flag}, 2'b01);
    chk("alu_pc", pc, 8'h0A);

    // PC increment wraps 0xFF -> 0x00
    clear_rom();
    rom[8'h00] = 8'h7C; rom[8'hFD] = 8'h30; rom[8'h01] = 8'hF0;
    run_prog("wrapinc", 0, n);
    chk("wrapinc_cycles", n, 17);
    chk("wrapinc_seen", wrap_inc, 1);
    chk("wrapinc_pc", pc, 8'h02);

    // Branch target wraps: BZ +7 at 0xFE lands on 0x06
    clear_rom();
    rom[8'h00] = 8'h30; rom[8'h01] = 8'h6A; rom[8'hFE] = 8'h67; rom[8'h06] = 8'hF0;
    run_prog("wrapbr", 0, n);
    chk("wrapbr_cycles", n, 17);
    chk("wrapbr_seen", wrap_br, 1);
    chk("wrapbr_pc", pc, 8'h07);

    // Reset pulse while LOADI waits for its immediate
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h55;
    ack_delay = 3;
    resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rf[0] = 8'hAA;
    rf_pulses = 0;
    resetn = 1'b1;
    n = 0;
    @(posedge CLOCK_50); #1;
    while (!(bus.imem_req && bus.imem_addr == 8'h01) && n < 50) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    chk("mrst_in_imm", bus.imem_req && (bus.imem_addr == 8'h01), 1);
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("mrst_req",  bus.imem_req,  0);
    chk("mrst_addr", bus.imem_addr, 0);
    chk("mrst_rfw",  RFWrite,       0);
    chk("mrst_out",  {regA, regB, regW, dataW, pc, zero_flag, neg_flag, halted, illegal}, 0);
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("mrst_refetch", {bus.imem_req, bus.imem_addr}, 9'h100);
    chk("mrst_R0_kept", rf[0], 8'hAA);
    chk("mrst_no_write", rf_pulses, 0);

    // Undefined opcode 0x80
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hF0;
    run_prog("ill", 0, n);
`ifdef CPU_ILLEGAL_TRAP_EN
    chk("ill_cycles", n, 2);
    chk("ill_flag", illegal, 1);
    chk("ill_pc", pc, 8'h01);
`else
    chk("ill_cycles", n, 5);
    chk("ill_flag", illegal, 0);
    chk("ill_pc", pc, 8'h02);
`endif
    chk("ill_halted", halted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control and execute stage for the 8-bit DE10-Lite soft CPU. It fetches 8-bit instructions from an instruction memory through a req/ack handshake and decodes them. It drives the read and write ports of the four-entry 8-bit register file and consumes that file's combinational read data. It computes ALU results and write-back data, and maintains the PC and the Z/N flags.

## Interface
Parameters: none; all widths fixed (8-bit data/PC, 2-bit register index).
- CLOCK_50  in  1  system clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- imem_addr  out  8  instruction fetch address (= PC or PC of immediate byte)
- imem_req  out  1  fetch request; held until ack
- imem_rdata  in  8  fetched byte; valid in the cycle imem_ack=1
- imem_ack  in  1  fetch complete; sampled only while imem_req=1
- RFWrite  out  1  register-file write enable
- regA  out  2  read port A index (= IR[3:2], rx)
- regB  out  2  read port B index (= IR[1:0], ry)
- regW  out  2  write index (= IR[3:2], rx)
- dataW  out  8  write-back data
- dataA  in  8  register-file read data A (combinational from regA)
- dataB  in  8  register-file read data B (combinational from regB)
- pc  out  8  current PC (debug / 7-seg)
- zero_flag  out  1  Z flag
- neg_flag  out  1  N flag (result bit 7)
- halted  out  1  high in HALT state
- illegal  out  1  undefined-opcode trap (see Configuration)

## Operation
- Instruction: [7:4] opcode, [3:2] rx, [1:0] ry. Opcodes:
  - 0x0: NOP.
  - 0x1: LOADI rx, imm. Two bytes; rx <- next byte.
  - 0x2: ADD rx <- rx+ry. 0x3: SUB rx <- rx-ry. 0x4: NAND rx <- ~(rx&ry).
  - 0x5: MOV rx <- ry.
  - 0x6: BZ off. 0x7: BNZ off. off = sign-extended {rx,ry}, target = PC_next + off.
  - 0xF: HALT.
  - 0x8–0xE: undefined.
- Arithmetic is mod 256; there is no carry. ADD/SUB/NAND update Z (result==0) and N (result[7]). LOADI, MOV, NOP and branches leave the flags unchanged.
- States:
  - IDLE: entered on reset; goes to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=PC. On ack, IR <- imem_rdata and go to DECODE.
  - DECODE: PC <- PC+1. LOADI goes to IMM; HALT goes to HALT; all others go to EXEC.
  - IMM: imem_req=1, imem_addr=PC. On ack, latch the immediate, PC <- PC+1, go to EXEC.
  - EXEC: RFWrite=1 for LOADI/ADD/SUB/NAND/MOV. Taken branches load PC. Go to FETCH.
  - HALT: terminal until reset; halted=1, PC frozen.
- regA/regB/regW decode from IR in all states; RFWrite is asserted only in EXEC. dataW is driven in EXEC: ALU result, dataB for MOV, or the immediate for LOADI.
- PC wraps 0xFF -> 0x00 on increment and on branch target arithmetic.

## Timing
- Reset values:
  - imem_req=0, imem_addr=0, RFWrite=0, regA=regB=regW=0, dataW=0.
  - pc=0, zero_flag=0, neg_flag=0, halted=0, illegal=0.
  - IR=0, state=IDLE.
- First imem_req=1 occurs in the cycle after resetn rises (IDLE lasts 1 cycle).
- Handshake: imem_addr is stable while imem_req=1. Same-cycle ack is allowed, giving a 1-cycle fetch; each wait cycle adds 1. imem_ack outside FETCH/IMM is ignored.
- Latency with zero-wait memory:
  - ALU/MOV/NOP/branch: 3 cycles (FETCH, DECODE, EXEC).
  - LOADI: 4 cycles.
  - HALT: 2 cycles to halted=1.
- The register-file write lands on the rising edge that ends EXEC. Flags and PC update on the same edge.
- Reset asserted mid-operation: on the next edge, everything returns to reset values. An outstanding fetch is abandoned (imem_req drops), and no partial write occurs.

## Configuration
- CPU_ILLEGAL_TRAP_EN defined: opcodes 0x8–0xE go DECODE -> HALT, with illegal=1 and halted=1 until reset.
- CPU_ILLEGAL_TRAP_EN not defined: opcodes 0x8–0xE execute as NOP (3 cycles), and illegal is tied 0.

## Test plan
- Straight-line program 0x14,0x05,0x18,0x03,0x36,0xF0, zero-wait ROM -> R1=2, R2=3, Z=0, N=0, halted=1, pc=0x06. RFWrite pulses exactly 3 times, each 1 cycle.
- Loop 0x10,0x03,0x14,0x01,0x31,0x7E,0xF0 -> SUB executes 3 times and BNZ branches to 0x04 twice. Final R0=0, Z=1, pc=0x07.
- ROM with ack delayed 3 cycles per fetch -> imem_addr is held stable while req=1, and results match the zero-wait run. LOADI takes 10 cycles.
- Wrap: PC=0xFF holding NOP -> next fetch address 0x00. BZ with off=+7 at 0xFE and Z=1 -> target 0x06.
- resetn low for 1 cycle while imem_req=1 in IMM of a LOADI -> no RFWrite, and all outputs are at reset values next cycle. The refetch starts at address 0x00.
- Opcode 0x80 -> with CPU_ILLEGAL_TRAP_EN: illegal=1 and halted=1 two cycles after ack. Without the macro: treated as NOP and the next fetch proceeds.
